banco_registros_param: RTL and testbench
========================================

Name: banco_registros_param

Overview:
Parametrised successor to the single-cycle MIPS register bank. It holds NREGS registers of DATA_W bits, with NRD combinational read ports and one clocked write port. Writes take per-byte enables, register 0 is hardwired to zero, and write-to-read bypass is built in. After reset, a hardware sweep clears every entry, so no file preload is needed. It sits between decode (read addresses) and writeback (write port) in the 32-bit datapath.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NREGS, 32, number of registers; power of two, at least 2.
ADDR_W, $clog2(NREGS), register address width; derived, not overridden.
NRD, 2, number of read ports, 1..4.
ZERO_R0, 1, when 1 register 0 reads 0 and ignores writes; when 0 it is an ordinary register.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
Read_Reg  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
Read_data  out  NRD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
Write_Reg  in  ADDR_W  write address.
Write_Data  in  DATA_W  write data.
Write_Be  in  DATA_W/8  byte enables; bit i enables byte i.
RegWrite  in  1  write request.
Busy  out  1  clear sweep in progress.
Wr_Ack  out  1  registered; 1 the cycle after a write is accepted.

Behaviour:
- Reset: any edge with rst=1 sets sweep counter to 0, Busy=1 and Wr_Ack=0. Array contents are not touched on that edge.
- Reset sweep:
  - Each edge with rst=0 and Busy=1 writes BR[cnt]=0 and increments cnt.
  - On the edge that clears entry NREGS-1, Busy goes to 0.
  - Busy is therefore high for exactly NREGS cycles after rst falls.
  - rst reasserted mid-sweep restarts the sweep at cnt=0.
- Outputs at reset: Busy=1, Wr_Ack=0, Read_data all zeros (reads are forced to 0 while Busy).
- Write acceptance: a write is accepted on an edge when rst=0, Busy=0, RegWrite=1, and not (ZERO_R0=1 and Write_Reg=0).
- Write effect: for each byte i with Write_Be[i]=1, BR[Write_Reg] byte i takes Write_Data byte i. Other bytes hold.
- Write_Be=0 with RegWrite=1: the write is still accepted (Wr_Ack pulses) but the array is unchanged.
- Writes while Busy or rst are dropped with no Wr_Ack. The source must retry or gate on Busy.
- Wr_Ack: registered. It is high for one cycle after each accepted write and stays high across back-to-back writes.
- Read port k, combinational, priority order:
  1. Busy=1 gives 0.
  2. ZERO_R0=1 and address=0 gives 0.
  3. Write would be accepted this cycle and Write_Reg equals the read address gives the merged value: Write_Data bytes where Write_Be is set, stored bytes elsewhere.
  4. Otherwise the stored BR[address].
- Multiple read ports may hit the same address or the bypass simultaneously; each port resolves independently.
- Out-of-range addresses cannot occur because NREGS is a power of two.
- No latency on reads. Written data is visible on the same cycle via bypass and from the array after the edge.

Decomposition:
- Shared package regfile_pkg holds the byte-merge function (old, new, be) → merged, the Busy/sweep state encoding (SWEEP, READY), and the default DATA_W and NREGS constants.
- One sub-module is natural: banco_rd_port. It is a single read port with bypass and zero handling, instantiated NRD times by generate.
- The sweep counter and write logic stay in the top level.

Test Plan:
- Reset sweep: rst=1 for 2 cycles, then 0, NREGS=32 → Busy high for exactly 32 cycles after rst falls. All reads are 0 throughout and after; a write attempted at cycle 5 gives no Wr_Ack and no effect.
- Write/read: write R5=0xDEADBEEF with Be=4'hF → same-cycle Read_Reg0=5 gives 0xDEADBEEF via bypass; next cycle 0xDEADBEEF from the array; Wr_Ack=1 for one cycle.
- Byte enables: R5=0xDEADBEEF, then write 0x11223344 with Be=4'b0101 → R5 reads 0xDE22BE44.
- Register zero: write R0=0xFFFFFFFF → Wr_Ack stays 0 and Read_Reg=0 returns 0. Repeat with ZERO_R0=0 → reads 0xFFFFFFFF.
- Multi-port: NRD=2, both ports address R7 while R7 is written with 0x00000042 → both ports show 0x00000042 in the same cycle. Port 1 on R8 shows the stored R8 value.
- Mid-sweep reset: rst pulsed at sweep cycle 10 → Busy is high for another full 32 cycles after rst falls again, and all entries read 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register bank.
// Holds the default geometry, the sweep/ready state encoding and the
// byte-merge helper used by both the write path and the read bypass.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NREGS  = 32;

  // Widest register the merge helper handles; callers widen/truncate around it.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } sweep_state_e;

  // Replace each byte of old_v whose enable is set with the same byte of new_v.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/banco_rd_port.sv
// Single combinational read port of the register bank.
// Ports:
//   busy        - clear sweep in progress, forces the port to 0
//   wr_accept   - a write is being accepted this cycle
//   wr_addr     - write address
//   wr_data     - write data
//   wr_be       - write byte enables
//   rd_addr     - read address
//   stored_data - array contents at rd_addr
//   rd_data_c   - resolved read value (combinational)
module banco_rd_port #(
  parameter int unsigned DATA_W  = regfile_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              busy,
  input  logic              wr_accept,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  output logic [DATA_W-1:0] rd_data_c
);
  import regfile_pkg::*;

  logic [DATA_W-1:0] merged_c;

  assign merged_c = DATA_W'(byte_merge(MAX_DATA_W'(stored_data),
                                       MAX_DATA_W'(wr_data),
                                       MAX_BE_W'(wr_be)));

  // Priority: sweep, hardwired zero, same-cycle write bypass, array.
  always_comb begin
    rd_data_c = stored_data;
    if (busy) begin
      rd_data_c = '0;
    end else if (ZERO_R0 && (rd_addr == '0)) begin
      rd_data_c = '0;
    end else if (wr_accept && (wr_addr == rd_addr)) begin
      rd_data_c = merged_c;
    end
  end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register bank: NREGS x DATA_W, NRD combinational read
// ports, one clocked byte-enabled write port, optional hardwired R0,
// write-to-read bypass and a post-reset clearing sweep.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   Read_Reg   - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   Read_data  - packed read data, port k at [k*DATA_W +: DATA_W]
//   Write_Reg  - write address
//   Write_Data - write data
//   Write_Be   - byte enables, bit i enables byte i
//   RegWrite   - write request
//   Busy       - clear sweep in progress
//   Wr_Ack     - high the cycle after an accepted write
module banco_registros_param #(
  parameter int unsigned DATA_W  = regfile_pkg::DEF_DATA_W,
  parameter int unsigned NREGS   = regfile_pkg::DEF_NREGS,
  parameter int unsigned NRD     = 2,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned ADDR_W = $clog2(NREGS),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] Read_Reg,
  output logic [NRD*DATA_W-1:0] Read_data,
  input  logic [ADDR_W-1:0]     Write_Reg,
  input  logic [DATA_W-1:0]     Write_Data,
  input  logic [BE_W-1:0]       Write_Be,
  input  logic                  RegWrite,
  output logic                  Busy,
  output logic                  Wr_Ack
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  sweep_state_e      state_q, state_nx;
  logic [ADDR_W-1:0] cnt_q, cnt_nx;
  logic              wr_ack_q, wr_ack_nx;
  logic              clr_en_c;
  logic              wr_accept_c;
  logic [DATA_W-1:0] merged_wr_c;
  logic [DATA_W-1:0] br [NREGS];

  assign Busy   = (state_q == SWEEP);
  assign Wr_Ack = wr_ack_q;

  // R0 writes are refused outright when it is hardwired, so no ack.
  assign wr_accept_c = !rst && !Busy && RegWrite &&
                       !(ZERO_R0 && (Write_Reg == '0));

  assign merged_wr_c = DATA_W'(byte_merge(MAX_DATA_W'(br[Write_Reg]),
                                          MAX_DATA_W'(Write_Data),
                                          MAX_BE_W'(Write_Be)));

  // State register: sweep control and write acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      wr_ack_q <= wr_ack_nx;
    end
  end

  // Next state: walk every entry once, then serve writes.
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    wr_ack_nx = 1'b0;
    clr_en_c  = 1'b0;
    case (state_q)
      SWEEP: begin
        clr_en_c = 1'b1;
        cnt_nx   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) state_nx = READY;
      end
      READY: begin
        wr_ack_nx = wr_accept_c;
      end
      default: state_nx = SWEEP;
    endcase
  end

  // Array update; the reset edge itself leaves contents alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en_c) begin
        br[cnt_q] <= '0;
      end else if (wr_accept_c) begin
        br[Write_Reg] <= merged_wr_c;
      end
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;

    assign addr   = Read_Reg[k*ADDR_W +: ADDR_W];
    assign stored = br[addr];

    banco_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) u_rd_port (
      .busy       (Busy),
      .wr_accept  (wr_accept_c),
      .wr_addr    (Write_Reg),
      .wr_data    (Write_Data),
      .wr_be      (Write_Be),
      .rd_addr    (addr),
      .stored_data(stored),
      .rd_data_c  (Read_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: one instance with R0
// hardwired, one with R0 as an ordinary register, sharing stimulus.
module tb_banco_registros_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic [2*AW-1:0] read_reg;
  logic [2*DW-1:0] rd_z, rd_nz;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [3:0]    write_be;
  logic          reg_write;
  logic          busy_z, busy_nz, ack_z, ack_nz;

  int total = 0;
  int bad   = 0;

  banco_registros_param #(.DATA_W(32), .NREGS(32), .NRD(2), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .Read_Reg(read_reg), .Read_data(rd_z),
    .Write_Reg(write_reg), .Write_Data(write_data), .Write_Be(write_be),
    .RegWrite(reg_write), .Busy(busy_z), .Wr_Ack(ack_z)
  );

  banco_registros_param #(.DATA_W(32), .NREGS(32), .NRD(2), .ZERO_R0(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .Read_Reg(read_reg), .Read_data(rd_nz),
    .Write_Reg(write_reg), .Write_Data(write_data), .Write_Be(write_be),
    .RegWrite(reg_write), .Busy(busy_nz), .Wr_Ack(ack_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_reg = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    write_reg  = a;
    write_data = d;
    write_be   = be;
    reg_write  = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0; write_be = '0;
    set_rd(5'd3, 5'd31);

    // Reset held for two edges.
    tick(); tick();
    chk("rst_busy", 64'(busy_z), 64'd1);
    chk("rst_ack", 64'(ack_z), 64'd0);
    chk("rst_rdata", 64'(rd_z), 64'd0);

    // Sweep: count busy cycles, attempt a write to R3 at cycle 5.
    rst = 1'b0;
    n = 0;
    while (busy_z && n < 40) begin
      #1;
      chk("sweep_rd_zero", 64'(rd_z), 64'd0);
      if (n == 5) wr(5'd3, 32'hFFFF_FFFF, 4'hF);
      else reg_write = 1'b0;
      tick();
      if (n == 5) chk("sweep_wr_noack", 64'(ack_z), 64'd0);
      n++;
    end
    reg_write = 1'b0;
    chk("sweep_len", 64'(n), 64'd32);
    #1;
    chk("post_sweep_r3_r31", 64'(rd_z), 64'd0);
    chk("post_sweep_nz", 64'(rd_nz), 64'd0);

    // Full write with same-cycle bypass.
    set_rd(5'd5, 5'd6);
    wr(5'd5, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("bypass_p0", 64'(rd_z[31:0]), 64'hDEAD_BEEF);
    chk("bypass_p1", 64'(rd_z[63:32]), 64'd0);
    chk("ack_before_edge", 64'(ack_z), 64'd0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("array_r5", 64'(rd_z[31:0]), 64'hDEAD_BEEF);
    chk("ack_pulse", 64'(ack_z), 64'd1);
    tick();
    chk("ack_drop", 64'(ack_z), 64'd0);

    // Byte enables 0101 merge into existing R5.
    wr(5'd5, 32'h1122_3344, 4'b0101);
    #1;
    chk("be_bypass", 64'(rd_z[31:0]), 64'hDE22_BE44);
    tick();
    reg_write = 1'b0;
    #1;
    chk("be_array", 64'(rd_z[31:0]), 64'hDE22_BE44);

    // Back-to-back writes keep Wr_Ack high; Be=0 still acks without effect.
    set_rd(5'd9, 5'd10);
    wr(5'd9, 32'h0000_AAAA, 4'hF);
    tick();
    chk("b2b_ack1", 64'(ack_z), 64'd1);
    wr(5'd10, 32'h0000_BBBB, 4'hF);
    tick();
    chk("b2b_ack2", 64'(ack_z), 64'd1);
    wr(5'd9, 32'hFFFF_FFFF, 4'h0);
    #1;
    chk("be0_bypass", 64'(rd_z[31:0]), 64'h0000_AAAA);
    tick();
    reg_write = 1'b0;
    #1;
    chk("be0_ack", 64'(ack_z), 64'd1);
    chk("be0_array", 64'(rd_z), {32'h0000_BBBB, 32'h0000_AAAA});
    tick();
    chk("b2b_ack_end", 64'(ack_z), 64'd0);

    // Register zero: hardwired vs ordinary.
    set_rd(5'd0, 5'd0);
    wr(5'd0, 32'hFFFF_FFFF, 4'hF);
    #1;
    chk("r0_bypass_z", 64'(rd_z[31:0]), 64'd0);
    chk("r0_bypass_nz", 64'(rd_nz[31:0]), 64'hFFFF_FFFF);
    tick();
    reg_write = 1'b0;
    #1;
    chk("r0_ack_z", 64'(ack_z), 64'd0);
    chk("r0_ack_nz", 64'(ack_nz), 64'd1);
    chk("r0_read_z", 64'(rd_z), 64'd0);
    chk("r0_read_nz", 64'(rd_nz), {32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // Multi-port: preload R8, then both ports on R7 during its write.
    wr(5'd8, 32'h1234_5678, 4'hF);
    tick();
    set_rd(5'd7, 5'd7);
    wr(5'd7, 32'h0000_0042, 4'hF);
    #1;
    chk("mp_both_r7", 64'(rd_z), {32'h0000_0042, 32'h0000_0042});
    set_rd(5'd7, 5'd8);
    #1;
    chk("mp_p0_r7_p1_r8", 64'(rd_z), {32'h1234_5678, 32'h0000_0042});
    tick();
    reg_write = 1'b0;

    // Mid-sweep reset restarts the full sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy_before", 64'(busy_z), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy_z && n < 40) begin
      tick();
      n++;
    end
    chk("mid_sweep_len", 64'(n), 64'd32);
    set_rd(5'd5, 5'd7);
    #1;
    chk("mid_clear_r5_r7", 64'(rd_z), 64'd0);
    set_rd(5'd8, 5'd0);
    #1;
    chk("mid_clear_r8_r0_nz", 64'(rd_nz), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
